// File: rtl/sha256_pkg.sv
// ----------------------------------------------------------------------------
// sha256_pkg
// Shared types and constants for the sha256 arbiter slice.
//   msg_t       : 32-byte message presented to the sha256 core (byte 31 first)
//   digest_t    : 32-byte digest returned by the core (byte 31 first)
//   SHA256_IV   : standard initial hash words H0..H7 (H0 in the top word)
//   arb_state_e : arbiter FSM encoding
// ----------------------------------------------------------------------------
package sha256_pkg;

   typedef logic [31:0][7:0] msg_t;
   typedef logic [31:0][7:0] digest_t;

   localparam logic [7:0][31:0] SHA256_IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } arb_state_e;

endpackage

// File: rtl/sha256_arbiter_rr_pick.sv
// ----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: first set request searching upward from
// the pointer, wrapping modulo NREQ.
//   i_req : request vector
//   i_ptr : highest-priority index (must be < NREQ)
//   o_gnt : one-hot grant (zero when no request)
//   o_idx : encoded grant index (zero when no request)
//   o_any : at least one request present
// ----------------------------------------------------------------------------
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IDW-1:0]  i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [IDW-1:0]  o_idx,
   output logic            o_any
);

   always_comb begin
      int j;
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      j     = 0;
      // Walk from the farthest offset down to offset 0 so the candidate
      // closest to the pointer is the last one written and therefore wins.
      for (int i = NREQ - 1; i >= 0; i--) begin
         j = int'(i_ptr) + i;
         if (j >= NREQ) j = j - NREQ;
         if (i_req[j]) begin
            o_idx = IDW'(j);
            o_any = 1'b1;
         end
      end
      if (o_any) o_gnt[o_idx] = 1'b1;
   end

endmodule

// File: rtl/sha256_arbiter.sv
// ----------------------------------------------------------------------------
// sha256_arbiter
// Shares one sha256 core among NREQ requesters with round-robin grant and a
// single job in flight. A watchdog aborts a job the core never answers,
// pulsing core_rst and returning an error response.
//   clk, rst        : clock, synchronous active-high reset
//   req_valid/ready : per-requester request / one-hot accept strobe
//   req_data        : per-requester 32-byte message
//   resp_*          : valid/ready response carrying id, digest and error flag
//   core_rst        : one-cycle reset pulse to the core (OR with rst outside)
//   core_in_*       : job issue to the core
//   core_out_*      : digest from the core
// ----------------------------------------------------------------------------
module sha256_arbiter
   import sha256_pkg::*;
#(
   parameter int NREQ    = 4,
   parameter int IDW     = $clog2(NREQ),
   parameter int TIMEOUT = 1024
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  msg_t [NREQ-1:0]     req_data,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [IDW-1:0]      resp_id,
   output digest_t             resp_data,
   output logic                resp_err,
   output logic                core_rst,
   output logic                core_in_valid,
   output msg_t                core_in_data,
   input  logic                core_out_valid,
   input  digest_t             core_out_res
);

   localparam int            CW   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   arb_state_e     r_state;
   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_gnt;
   msg_t           r_msg;
   digest_t        r_digest;
   logic           r_err;
   logic [CW-1:0]  r_cnt;
   logic           r_core_rst;

   logic [NREQ-1:0] w_gnt;
   logic [IDW-1:0]  w_idx;
   logic            w_any;
   logic [IDW-1:0]  w_ptr_nxt;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .i_req (req_valid),
      .i_ptr (r_ptr),
      .o_gnt (w_gnt),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // Priority moves to the requester just after the one served.
   assign w_ptr_nxt = (r_gnt == IDW'(NREQ - 1)) ? '0 : r_gnt + IDW'(1);

   assign req_ready     = (r_state == ST_IDLE) ? w_gnt : '0;
   assign core_in_valid = (r_state == ST_ISSUE);
   assign core_in_data  = r_msg;
   assign resp_valid    = (r_state == ST_RESP);
   assign resp_id       = r_gnt;
   assign resp_data     = r_digest;
   assign resp_err      = r_err;
   assign core_rst      = r_core_rst;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_ptr      <= '0;
         r_gnt      <= '0;
         r_msg      <= '0;
         r_digest   <= '0;
         r_err      <= 1'b0;
         r_cnt      <= '0;
         r_core_rst <= 1'b0;
      end else begin
         r_core_rst <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_gnt   <= w_idx;
                  r_msg   <= req_data[w_idx];
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               r_cnt   <= '0;
               r_state <= ST_WAIT;
            end
            ST_WAIT: begin
               // A digest arriving on the timeout cycle is still delivered.
               if (core_out_valid) begin
                  r_digest <= core_out_res;
                  r_err    <= 1'b0;
                  r_state  <= ST_RESP;
               end else if (r_cnt == LAST) begin
                  r_digest   <= '0;
                  r_err      <= 1'b1;
                  r_core_rst <= 1'b1;
                  r_state    <= ST_RESP;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_RESP: begin
               if (resp_ready) begin
                  r_ptr   <= w_ptr_nxt;
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
